// File: rtl/gpio_key_model_if.sv
// gpio_key_model_if
//   Command handshake and GPIO drive bundle between a test sequencer
//   (master) and the key-press waveform model (slave).
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_pin_i               : target pin index, one extra MSB so that
//                             out-of-range pins can be detected
//   cmd_hold_i              : settled-press duration in cycles
//   cmd_bounce_i            : bounce count per edge
//   abort_i                 : cancel the running command
//   key_o                   : registered drive to the GPIO inputs
//   busy_o/done_o/err_o     : command status
interface gpio_key_model_if #(
    parameter int GPIO_NUM = 32
);
    localparam int PIN_W = $clog2(GPIO_NUM) + 1;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [PIN_W-1:0]    cmd_pin_i;
    logic [15:0]         cmd_hold_i;
    logic [3:0]          cmd_bounce_i;
    logic                abort_i;
    logic [GPIO_NUM-1:0] key_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport master (
        output cmd_valid_i, cmd_pin_i, cmd_hold_i, cmd_bounce_i, abort_i,
        input  cmd_ready_o, key_o, busy_o, done_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_pin_i, cmd_hold_i, cmd_bounce_i, abort_i,
        output cmd_ready_o, key_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/gpio_key_model.sv
// gpio_key_model
//   Drives one GPIO input pin at a time with a key-press waveform:
//   press bounce (2N+1 segments ending active), settled hold, release
//   bounce (2N+1 segments ending idle). Every other pin stays idle.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   bus     : command handshake, abort, GPIO drive and status (slave side)
module gpio_key_model #(
    parameter int   GPIO_NUM   = 32,
    parameter int   BOUNCE_CYC = 4,
    parameter logic IDLE_LVL   = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    gpio_key_model_if.slave bus
);
    localparam int PIN_W = $clog2(GPIO_NUM) + 1;
    localparam int CYC_W = $clog2(BOUNCE_CYC + 1);
    localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(BOUNCE_CYC - 1);
    localparam logic [GPIO_NUM-1:0] IDLE_VEC = {GPIO_NUM{IDLE_LVL}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]          state;
    logic [4:0]          seg_cnt;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [15:0]         hold_cnt;
    logic [GPIO_NUM-1:0] key_q;
    logic                done_q;
    logic                err_q;

    logic [PIN_W-1:0]    pin_q;
    logic [15:0]         hold_last_q;
    logic [4:0]          seg_last_q;

    logic accept, pin_bad, seg_end, last_seg, hold_end;

    // Whole-bus drive with only the selected pin possibly active.
    function automatic logic [GPIO_NUM-1:0] drive(input logic [PIN_W-1:0] pin,
                                                  input logic active);
        logic [GPIO_NUM-1:0] mask;
        mask = GPIO_NUM'(1) << pin;
        return active ? (IDLE_VEC ^ mask) : IDLE_VEC;
    endfunction

    assign accept   = bus.cmd_valid_i && (state == S_IDLE);
    assign pin_bad  = bus.cmd_pin_i >= PIN_W'(GPIO_NUM);
    assign seg_end  = (cyc_cnt == CYC_LAST);
    assign last_seg = (seg_cnt == seg_last_q);
    assign hold_end = (hold_cnt == hold_last_q);

    // Command parameters: captured once per accepted command, no reset needed.
    // Hold of 0 behaves as 1, so the terminal hold count saturates at 0.
    always_ff @(posedge clk_i) begin
        if (accept && !pin_bad) begin
            pin_q       <= bus.cmd_pin_i;
            hold_last_q <= (bus.cmd_hold_i == 16'd0) ? 16'd0 : bus.cmd_hold_i - 16'd1;
            seg_last_q  <= {bus.cmd_bounce_i, 1'b0};
        end
    end

    // Sequencer. Segment parity selects the level: even press segments
    // are active, even release segments are idle, so the level for the
    // next segment is derived from the current segment's LSB.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            seg_cnt  <= '0;
            cyc_cnt  <= '0;
            hold_cnt <= '0;
            key_q    <= IDLE_VEC;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    if (pin_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        state    <= S_PRESS;
                        seg_cnt  <= '0;
                        cyc_cnt  <= '0;
                        hold_cnt <= '0;
                        key_q    <= drive(bus.cmd_pin_i, 1'b1);
                    end
                end
            end else if (bus.abort_i) begin
                state    <= S_IDLE;
                seg_cnt  <= '0;
                cyc_cnt  <= '0;
                hold_cnt <= '0;
                key_q    <= IDLE_VEC;
            end else if (state == S_PRESS) begin
                if (seg_end) begin
                    cyc_cnt <= '0;
                    if (last_seg) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end else begin
                        seg_cnt <= seg_cnt + 5'd1;
                        key_q   <= drive(pin_q, seg_cnt[0]);
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
            end else if (state == S_HOLD) begin
                if (hold_end) begin
                    state   <= S_RELEASE;
                    seg_cnt <= '0;
                    cyc_cnt <= '0;
                    key_q   <= IDLE_VEC;
                end else begin
                    hold_cnt <= hold_cnt + 16'd1;
                end
            end else begin
                if (seg_end) begin
                    cyc_cnt <= '0;
                    if (last_seg) begin
                        state    <= S_IDLE;
                        seg_cnt  <= '0;
                        hold_cnt <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        seg_cnt <= seg_cnt + 5'd1;
                        key_q   <= drive(pin_q, !seg_cnt[0]);
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
            end
        end
    end

    assign bus.key_o       = key_q;
    assign bus.cmd_ready_o = (state == S_IDLE);
    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
endmodule
